lc4_mul_seq: RTL and testbench



---
 rtl/lc4_mul_pkg.sv | 12 +
 rtl/lc4_mul_step.sv | 23 ++
 rtl/lc4_mul_seq.sv | 116 +++++++++++
 tb/tb_lc4_mul_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_mul_pkg.sv
// Shared types and defaults for the LC4 shift-and-add multiplier sequencer.
package lc4_mul_pkg;

    localparam int WORD_SIZE_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lc4_mul_step.sv
// One multiply iteration: check the multiplier LSB, conditionally add the
// multiplicand, then shift {carry, acc_hi, acc_lo} right by one.
module lc4_mul_step
    import lc4_mul_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic [WORD_SIZE-1:0] acc_hi,
    input  logic [WORD_SIZE-1:0] acc_lo,
    input  logic [WORD_SIZE-1:0] mcand,
    output logic [WORD_SIZE-1:0] next_hi,
    output logic [WORD_SIZE-1:0] next_lo
);

    logic [WORD_SIZE:0] sum;

    // The carry out of the add lands in sum[WORD_SIZE] and is shifted back in,
    // so the full-width product never overflows.
    assign sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign next_hi = sum[WORD_SIZE:1];
    assign next_lo = {sum[0], acc_lo[WORD_SIZE-1:1]};

endmodule

// File: rtl/lc4_mul_seq.sv
// Multi-cycle WORD_SIZE x WORD_SIZE unsigned multiplier; one step per clock,
// fixed WORD_SIZE-cycle latency, valid/ready on both request and product.
module lc4_mul_seq
    import lc4_mul_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WORD_SIZE-1:0] i_a,
    input  logic [WORD_SIZE-1:0] i_b,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] o_hi,
    output logic [WORD_SIZE-1:0] o_lo,
    output logic                 o_busy
);

    localparam int CNT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WORD_SIZE-1:0] acc_hi_q;
    logic [WORD_SIZE-1:0] acc_lo_q;
    logic [WORD_SIZE-1:0] mcand_q;
    logic [WORD_SIZE-1:0] step_hi;
    logic [WORD_SIZE-1:0] step_lo;
    logic                 accept;
    logic                 step_en;

    lc4_mul_step #(
        .WORD_SIZE (WORD_SIZE)
    ) u_step (
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .mcand   (mcand_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides everything, so accept/step are only raised without it.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step_en = 1'b0;
        if (i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        accept  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    step_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (i_flush || accept) begin
            cnt_q <= '0;
        end else if (step_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
        end else if (accept) begin
            acc_hi_q <= '0;
            acc_lo_q <= i_b;
            mcand_q  <= i_a;
        end else if (step_en) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_busy  = (state_q == ST_RUN);
    assign o_valid = (state_q == ST_DONE);
    assign o_hi    = acc_hi_q;
    assign o_lo    = acc_lo_q;

endmodule

// File: tb/tb_lc4_mul_seq.sv
// Scoreboard bench for lc4_mul_seq: a 64-bit and a 16-bit instance run side by side.
module tb_lc4_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] prod;
        int           acyc;
    } exp_t;

    exp_t q64[$];
    exp_t q16[$];
    int   total = 0;
    int   bad   = 0;
    bit   done64 = 1'b0;
    bit   done16 = 1'b0;
    bit   rr64 = 1'b0;

    // 64-bit instance
    logic        rst64_n = 1'b0, vld64 = 1'b0, flush64 = 1'b0, rdy64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        ordy64, oval64, busy64;
    logic [63:0] hi64, lo64;

    lc4_mul_seq #(.WORD_SIZE(64)) u64 (
        .clk     (clk),
        .rst_n   (rst64_n),
        .i_valid (vld64),
        .o_ready (ordy64),
        .i_a     (a64),
        .i_b     (b64),
        .i_flush (flush64),
        .o_valid (oval64),
        .i_ready (rdy64),
        .o_hi    (hi64),
        .o_lo    (lo64),
        .o_busy  (busy64)
    );

    // 16-bit instance
    logic        rst16_n = 1'b0, vld16 = 1'b0, flush16 = 1'b0, rdy16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ordy16, oval16, busy16;
    logic [15:0] hi16, lo16;

    lc4_mul_seq #(.WORD_SIZE(16)) u16 (
        .clk     (clk),
        .rst_n   (rst16_n),
        .i_valid (vld16),
        .o_ready (ordy16),
        .i_a     (a16),
        .i_b     (b16),
        .i_flush (flush16),
        .o_valid (oval16),
        .i_ready (rdy16),
        .o_hi    (hi16),
        .o_lo    (lo16),
        .o_busy  (busy16)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick64();
        @(negedge clk);
        if (rr64) rdy64 = 1'($urandom_range(0, 1));
    endtask

    task automatic tick16();
        @(negedge clk);
        rdy16 = 1'($urandom_range(0, 1));
    endtask

    task automatic issue64(input logic [63:0] a, input logic [63:0] b, input bit push);
        int n = 0;
        vld64 = 1'b1;
        a64 = a;
        b64 = b;
        while (!ordy64 && n < 500) begin
            tick64();
            n++;
        end
        if (n >= 500) chk("issue64_ready_timeout", 128'd0, 128'd1);
        if (push) q64.push_back('{prod: {64'd0, a} * {64'd0, b}, acyc: cyc + 1});
        tick64();
        vld64 = 1'b0;
    endtask

    task automatic wait_valid64();
        int n = 0;
        while (!oval64 && n < 200) begin
            tick64();
            n++;
        end
        if (n >= 200) chk("valid64_timeout", 128'd0, 128'd1);
    endtask

    // Monitors: pop one expectation on every rising o_valid.
    initial begin
        bit prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (oval64 && !prev) begin
                if (q64.size() == 0) begin
                    chk("valid64_unexpected", 128'd1, 128'd0);
                end else begin
                    e = q64.pop_front();
                    chk("prod64", {hi64, lo64}, e.prod);
                    chk("lat64", 128'(cyc - e.acyc), 128'd64);
                end
            end
            prev = oval64;
        end
    end

    initial begin
        bit prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (oval16 && !prev) begin
                if (q16.size() == 0) begin
                    chk("valid16_unexpected", 128'd1, 128'd0);
                end else begin
                    e = q16.pop_front();
                    chk("prod16", 128'({hi16, lo16}), e.prod);
                    chk("lat16", 128'(cyc - e.acyc), 128'd16);
                end
            end
            prev = oval16;
        end
    end

    // 64-bit directed then random traffic
    initial begin
        int bc;
        int n;
        logic [63:0] ra, rb;
        repeat (3) tick64();
        chk("rst_ready", 128'(ordy64), 128'd1);
        chk("rst_valid", 128'(oval64), 128'd0);
        chk("rst_busy", 128'(busy64), 128'd0);
        chk("rst_hilo", {hi64, lo64}, 128'd0);
        rst64_n = 1'b1;
        tick64();

        // Reset during RUN
        issue64(64'd3, 64'd5, 1'b0);
        repeat (9) tick64();
        chk("midrun_busy", 128'(busy64), 128'd1);
        rst64_n = 1'b0;
        #1;
        chk("midrst_ready", 128'(ordy64), 128'd1);
        chk("midrst_valid", 128'(oval64), 128'd0);
        chk("midrst_busy", 128'(busy64), 128'd0);
        chk("midrst_hilo", {hi64, lo64}, 128'd0);
        tick64();
        rst64_n = 1'b1;
        tick64();
        chk("postrst_idle", 128'({ordy64, busy64, oval64}), 128'b100);

        // Basic 3 x 5 with busy-length check
        issue64(64'd3, 64'd5, 1'b1);
        bc = 0;
        n = 0;
        while (!oval64 && n < 200) begin
            if (busy64) bc++;
            tick64();
            n++;
        end
        chk("basic_busy_cycles", 128'(bc), 128'd64);
        chk("basic_hilo", {hi64, lo64}, 128'd15);
        rdy64 = 1'b1;
        tick64();
        rdy64 = 1'b0;
        chk("basic_taken_idle", 128'({ordy64, oval64}), 128'b10);
        chk("basic_hold_lo", 128'(lo64), 128'd15);

        // All-ones operands
        issue64('1, '1, 1'b1);
        wait_valid64();
        chk("max_hi", 128'(hi64), 128'hFFFF_FFFF_FFFF_FFFE);
        chk("max_lo", 128'(lo64), 128'd1);
        rdy64 = 1'b1;
        tick64();
        rdy64 = 1'b0;

        // Backpressure with ignored i_valid pulses
        issue64(64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
        repeat (5) tick64();
        vld64 = 1'b1;
        a64 = 64'd7;
        b64 = 64'd7;
        chk("run_ready_low", 128'(ordy64), 128'd0);
        tick64();
        vld64 = 1'b0;
        wait_valid64();
        for (int i = 0; i < 20; i++) begin
            vld64 = (i == 5);
            chk("bp_hold", {63'd0, oval64, hi64, lo64}, {63'd1, 64'd1, 64'd0});
            if (i == 5) chk("done_ready_low", 128'(ordy64), 128'd0);
            tick64();
        end
        vld64 = 1'b0;
        rdy64 = 1'b1;
        tick64();
        rdy64 = 1'b0;
        repeat (3) tick64();
        chk("bp_no_extra", 128'({ordy64, busy64}), 128'b10);

        // Flush mid-RUN together with i_valid, then flush in IDLE with i_valid
        issue64(64'd7, 64'd9, 1'b0);
        repeat (29) tick64();
        flush64 = 1'b1;
        vld64 = 1'b1;
        a64 = 64'd2;
        b64 = 64'd2;
        tick64();
        flush64 = 1'b0;
        vld64 = 1'b0;
        chk("flush_idle", 128'({ordy64, busy64, oval64}), 128'b100);
        flush64 = 1'b1;
        vld64 = 1'b1;
        tick64();
        flush64 = 1'b0;
        vld64 = 1'b0;
        chk("flush_blocks_accept", 128'({ordy64, busy64}), 128'b10);
        repeat (70) tick64();
        rdy64 = 1'b1;
        issue64(64'd2, 64'd2, 1'b1);
        wait_valid64();
        chk("post_flush_lo", 128'(lo64), 128'd4);
        tick64();
        rdy64 = 1'b0;

        // Random traffic with random consumer backpressure
        rr64 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 1)) tick64();
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if (i % 97 == 0) ra = '1;
            issue64(ra, rb, 1'b1);
        end
        n = 0;
        while (q64.size() != 0 && n < 2000) begin
            tick64();
            n++;
        end
        rr64 = 1'b0;
        done64 = 1'b1;
    end

    // 16-bit random traffic
    initial begin
        int n;
        logic [15:0] ra, rb;
        repeat (3) tick16();
        rst16_n = 1'b1;
        tick16();
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 1)) tick16();
            ra = 16'($urandom());
            rb = 16'($urandom());
            if (i == 0) begin
                ra = '1;
                rb = '1;
            end
            vld16 = 1'b1;
            a16 = ra;
            b16 = rb;
            n = 0;
            while (!ordy16 && n < 200) begin
                tick16();
                n++;
            end
            if (n >= 200) chk("issue16_ready_timeout", 128'd0, 128'd1);
            q16.push_back('{prod: 128'({16'd0, ra} * {16'd0, rb}), acyc: cyc + 1});
            tick16();
            vld16 = 1'b0;
        end
        n = 0;
        while (q16.size() != 0 && n < 500) begin
            tick16();
            n++;
        end
        done16 = 1'b1;
    end

    initial begin
        while (!(done64 && done16) && cyc < 95000) @(negedge clk);
        if (!(done64 && done16)) chk("run_timeout", 128'd0, 128'd1);
        chk("q64_drained", 128'(q64.size()), 128'd0);
        chk("q16_drained", 128'(q16.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
